// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with a mem_ready handshake.
// Optional `RETIRE_COUNTER_EN adds a 32-bit retired-instruction counter on port instret.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        alu_src_b,
  output logic        alu_src_a_pc,
  output logic [3:0]  alu_op,
  output logic        illegal_instr,
  output logic        bus_error,
  output logic [2:0]  state
`ifdef RETIRE_COUNTER_EN
  ,
  output logic [31:0] instret
`endif
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD
  } iclass_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9
  } alu_op_t;

  localparam logic [3:0] LP_TIMEOUT = 4'(MEM_TIMEOUT);

  state_t     r_state;
  iclass_t    r_class;
  logic [2:0] r_func3;
  logic       r_func7_b5;
  logic [3:0] r_cnt;
  logic       r_illegal;
  logic       r_bus_err;

  iclass_t    w_class;
  logic       w_illegal;
  logic [3:0] w_cnt_inc;
  logic       w_timeout;
  alu_op_t    w_arith_op;
  alu_op_t    w_branch_op;

  always_comb begin
    case (opcode)
      7'b0110011: w_class = C_R;
      7'b0010011: w_class = C_IALU;
      7'b0000011: w_class = C_LOAD;
      7'b0100011: w_class = C_STORE;
      7'b1100011: w_class = C_BRANCH;
      7'b1101111: w_class = C_JAL;
      7'b1100111: w_class = C_JALR;
      7'b0110111: w_class = C_LUI;
      7'b0010111: w_class = C_AUIPC;
      default:    w_class = C_BAD;
    endcase
    w_illegal = (w_class == C_BAD) ||
                ((w_class == C_R) &&
                 !((func7 == 7'b0000000) ||
                   ((func7 == 7'b0100000) && ((func3 == 3'b000) || (func3 == 3'b101)))));
  end

  assign w_cnt_inc = r_cnt + 4'd1;
  assign w_timeout = !mem_ready && (w_cnt_inc == LP_TIMEOUT);

  always_comb begin
    case (r_func3)
      3'b000:  w_arith_op = ((r_class == C_R) && r_func7_b5) ? OP_SUB : OP_ADD;
      3'b001:  w_arith_op = OP_SLL;
      3'b010:  w_arith_op = OP_SLT;
      3'b011:  w_arith_op = OP_SLTU;
      3'b100:  w_arith_op = OP_XOR;
      3'b101:  w_arith_op = r_func7_b5 ? OP_SRA : OP_SRL;
      3'b110:  w_arith_op = OP_OR;
      default: w_arith_op = OP_AND;
    endcase
    case (r_func3[2:1])
      2'b10:   w_branch_op = OP_SLT;
      2'b11:   w_branch_op = OP_SLTU;
      default: w_branch_op = OP_SUB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_class    <= C_R;
      r_func3    <= '0;
      r_func7_b5 <= 1'b0;
      r_cnt      <= '0;
      r_illegal  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_cnt   <= '0;
            r_state <= S_DECODE;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_timeout) begin
              r_bus_err <= 1'b1;
              r_state   <= S_HALT;
            end
          end
        end
        S_DECODE: begin
          r_cnt      <= '0;
          r_class    <= w_class;
          r_func3    <= func3;
          r_func7_b5 <= func7[5];
          if (w_illegal) begin
            r_illegal <= 1'b1;
            r_state   <= S_HALT;
          end else begin
            r_state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          r_cnt <= '0;
          case (r_class)
            C_LOAD, C_STORE: r_state <= S_MEM;
            C_BRANCH:        r_state <= S_FETCH;
            default:         r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            r_cnt   <= '0;
            r_state <= (r_class == C_STORE) ? S_FETCH : S_WB;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_timeout) begin
              r_bus_err <= 1'b1;
              r_state   <= S_HALT;
            end
          end
        end
        S_WB: begin
          r_cnt   <= '0;
          r_state <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_HALT;
      endcase
    end
  end

  // Outputs are gated by rst_n so an in-flight request drops the moment reset asserts.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    alu_src_b    = 1'b0;
    alu_src_a_pc = 1'b0;
    alu_op       = OP_ADD;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_EXECUTE: begin
          case (r_class)
            C_R:    alu_op = w_arith_op;
            C_IALU: begin
              alu_op    = w_arith_op;
              alu_src_b = 1'b1;
            end
            C_LOAD, C_STORE: alu_src_b = 1'b1;
            C_BRANCH: begin
              alu_op   = w_branch_op;
              pc_write = branch_taken;
              pc_src   = 2'd1;
            end
            C_JAL: begin
              pc_write = 1'b1;
              pc_src   = 2'd1;
            end
            C_JALR: begin
              pc_write = 1'b1;
              pc_src   = 2'd2;
            end
            C_AUIPC: begin
              alu_src_a_pc = 1'b1;
              alu_src_b    = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = (r_class == C_STORE);
        end
        S_WB: begin
          reg_write = 1'b1;
          case (r_class)
            C_LOAD:        wb_sel = 2'd1;
            C_JAL, C_JALR: wb_sel = 2'd2;
            C_LUI:         wb_sel = 2'd3;
            default:       wb_sel = 2'd0;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign illegal_instr = r_illegal;
  assign bus_error     = r_bus_err;
  assign state         = r_state;

`ifdef RETIRE_COUNTER_EN
  logic [31:0] r_instret;
  logic        w_retire;

  assign w_retire = (r_state == S_WB) ||
                    ((r_state == S_EXECUTE) && (r_class == C_BRANCH)) ||
                    ((r_state == S_MEM) && mem_ready && (r_class == C_STORE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + 32'd1;
  end

  assign instret = r_instret;
`endif

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle RV32I control sequencer for the single-ported core.
- Consumes the decoded instruction fields (opcode, func3, func7) from the field splitter driven by the instruction register.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Drives datapath enables and ALU/mux selects; stalls on a memory ready handshake.

Parameters:
- MEM_TIMEOUT, 15, max cycles waiting for mem_ready in any memory state before flagging a bus error (4-bit counter; valid range 1..15).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  7  instruction bits [6:0]
- func3  input  3  instruction bits [14:12]
- func7  input  7  instruction bits [31:25]
- branch_taken  input  1  ALU compare result for the current branch
- mem_ready  input  1  memory has completed the current access
- mem_req  output  1  memory access request, held until mem_ready
- mem_we  output  1  1 = store, 0 = read (fetch/load)
- ir_write  output  1  latch fetched word into the instruction register
- pc_write  output  1  PC update strobe
- pc_src  output  2  0: PC+4; 1: PC+imm (branch/JAL); 2: (rs1+imm)&~1 (JALR)
- reg_write  output  1  register file write strobe
- wb_sel  output  2  0: ALU; 1: load data; 2: PC+4; 3: immediate (LUI)
- alu_src_b  output  1  0: rs2; 1: immediate
- alu_src_a_pc  output  1  1: ALU A = PC (AUIPC)
- alu_op  output  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
- illegal_instr  output  1  sticky: unsupported opcode/func seen
- bus_error  output  1  sticky: mem_ready timeout
- state  output  3  current state encoding, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=7.
- Reset (async, rst_n=0): state=FETCH; timeout counter=0; all strobes and selects 0; illegal_instr=0; bus_error=0. First fetch request is issued in the first cycle after deassertion.
- All outputs are Moore-decoded from the state and the registered opcode fields. No output depends combinationally on mem_ready except ir_write and pc_write in FETCH.
- FETCH:
  - mem_req=1, mem_we=0.
  - While mem_ready=0: stay in FETCH and increment the counter.
  - On mem_ready=1 in the same cycle: ir_write=1, pc_write=1, pc_src=0; next state DECODE; counter cleared.
- DECODE (1 cycle), classified on opcode:
  - Supported: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Anything else: set illegal_instr and go to HALT.
  - R-type with func7 not in {0000000, 0100000}, or func7=0100000 with func3 not in {000, 101}: also illegal.
- EXECUTE (1 cycle):
  - R/I: alu_op from func3 plus func7[5]. SUB only for R-type; SRA for R or I shift with func7[5]=1; I-type ADDI ignores func7.
  - LOAD/STORE: alu_op=ADD, alu_src_b=1; next state MEM.
  - BRANCH: alu_op=SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU. pc_write=branch_taken, pc_src=1; next state FETCH.
  - JAL/JALR: pc_write=1, pc_src=1 or 2; next state WB.
  - All other classes: next state WB.
- MEM:
  - mem_req=1, mem_we=1 for STORE.
  - Hold until mem_ready. STORE then goes to FETCH; LOAD goes to WB.
- WB (1 cycle):
  - reg_write=1.
  - wb_sel: LOAD=1, JAL/JALR=2, LUI=3, else 0.
  - Next state FETCH.
- Timeout: if the counter reaches MEM_TIMEOUT while in FETCH or MEM, set bus_error and go to HALT.
- HALT: all strobes 0. Only reset exits.
- Simultaneous events: mem_ready=1 on the same cycle the counter hits MEM_TIMEOUT counts as completion (no error).
- Reset mid-access: mem_req drops immediately (async).

Optional Feature:
- Macro RETIRE_COUNTER_EN.
- When defined: adds output port instret (width 32).
  - Reset value 0.
  - Increments by 1 on every transition into FETCH from EXECUTE, MEM or WB (one per retired instruction).
  - Wraps 0xFFFFFFFF to 0.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- R-type SUB (opcode 0110011, func3 000, func7 0100000), mem_ready=1 always -> states 0,1,2,4,0; alu_op=1 in EXECUTE; reg_write=1 and wb_sel=0 only in WB; 4 cycles per instruction.
- LOAD with mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles with mem_req=1, mem_we=0; then WB with wb_sel=1; no bus_error.
- BEQ with branch_taken=1, then with branch_taken=0 -> pc_write=1/pc_src=1 in EXECUTE only for the taken case; both return to FETCH without a WB cycle.
- Opcode 1111111 -> illegal_instr=1 after DECODE; state=7; strobes stay 0 for 20 cycles; rst_n pulse returns state=0 and clears the flag.
- FETCH with mem_ready held 0 (MEM_TIMEOUT=15) -> bus_error=1 and HALT after 15 cycles; repeat with mem_ready rising on cycle 15 -> normal DECODE, no error.
- With RETIRE_COUNTER_EN: run 5 mixed instructions (ADDI, SW, LW, JAL, BNE not taken) -> instret=5; async reset mid-MEM -> instret=0, mem_req=0 immediately.
